// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  start_i;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] hi_o;
  logic [DATA_WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MIPS-style multiply/divide unit with HI/LO result registers.
// Magnitudes are processed unsigned; signs are re-applied in a single FIX cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic          clk,
  input logic          reset,
  mult_div_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [W-1:0] f_neg(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*W-1:0] f_neg2(input logic [2*W-1:0] x);
    return ~x + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] f_mag(input logic [W-1:0] x, input logic is_signed);
    return (is_signed && x[W-1]) ? f_neg(x) : x;
  endfunction

  state_t               r_state;
  logic [2*W-1:0]       r_acc;
  logic [W-1:0]         r_opb;
  logic [W-1:0]         r_a_raw;
  logic [W-1:0]         r_hi;
  logic [W-1:0]         r_lo;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_b_zero;
  logic                 r_busy;
  logic                 r_done;

  logic [W:0]           w_mul_sum;
  logic [2*W-1:0]       w_mul_next;
  logic [2*W:0]         w_div_shift;
  logic [W:0]           w_div_diff;
  logic [2*W-1:0]       w_div_next;
  logic [2*W-1:0]       w_step;
  logic [2*W-1:0]       w_prod_fix;
  logic [W-1:0]         w_fix_hi;
  logic [W-1:0]         w_fix_lo;
  logic                 w_signed_op;
  logic                 w_sa;
  logic                 w_sb;

  assign w_signed_op = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
  assign w_sa        = w_signed_op & bus.a_i[W-1];
  assign w_sb        = w_signed_op & bus.b_i[W-1];

  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
  assign bus.hi_o   = r_hi;
  assign bus.lo_o   = r_lo;

  // One radix-2 iteration: shift-add multiply or restoring divide on r_acc.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*W-1:W]};
    if (r_acc[0]) begin
      w_mul_sum = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opb};
    end else begin
      w_mul_sum = {1'b0, r_acc[2*W-1:W]};
    end
    w_mul_next  = {w_mul_sum, r_acc[W-1:1]};

    w_div_shift = {r_acc, 1'b0};
    w_div_diff  = w_div_shift[2*W:W] - {1'b0, r_opb};
    if (w_div_shift[2*W:W] >= {1'b0, r_opb}) begin
      w_div_next = {w_div_diff[W-1:0], w_div_shift[W-1:1], 1'b1};
    end else begin
      w_div_next = w_div_shift[2*W-1:0];
    end

    if (r_is_div) begin
      w_step = w_div_next;
    end else begin
      w_step = w_mul_next;
    end
  end

  // Sign correction applied in FIX; divide-by-zero passes the raw dividend through.
  always_comb begin
    w_prod_fix = r_neg_q ? f_neg2(r_acc) : r_acc;
    if (r_is_div) begin
      if (r_b_zero) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = {W{1'b1}};
      end else begin
        w_fix_hi = r_neg_r ? f_neg(r_acc[2*W-1:W]) : r_acc[2*W-1:W];
        w_fix_lo = r_neg_q ? f_neg(r_acc[W-1:0]) : r_acc[W-1:0];
      end
    end else begin
      w_fix_hi = w_prod_fix[2*W-1:W];
      w_fix_lo = w_prod_fix[W-1:0];
    end
  end

  // Control FSM with registered busy/done and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= {(2*W){1'b0}};
      r_opb    <= {W{1'b0}};
      r_a_raw  <= {W{1'b0}};
      r_hi     <= {W{1'b0}};
      r_lo     <= {W{1'b0}};
      r_cnt    <= {CNT_WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            case (bus.op_i)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_is_div <= bus.op_i[1];
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_b_zero <= (bus.b_i == {W{1'b0}});
                r_a_raw  <= bus.a_i;
                r_cnt    <= {CNT_WIDTH{1'b0}};
                r_busy   <= 1'b1;
                r_state  <= ST_CALC;
                if (bus.op_i[1]) begin
                  r_acc <= {{W{1'b0}}, f_mag(bus.a_i, w_signed_op)};
                  r_opb <= f_mag(bus.b_i, w_signed_op);
                end else begin
                  r_acc <= {{W{1'b0}}, f_mag(bus.b_i, w_signed_op)};
                  r_opb <= f_mag(bus.a_i, w_signed_op);
                end
              end
              OP_MTHI: r_hi <= bus.a_i;
              OP_MTLO: r_lo <= bus.a_i;
              default: r_state <= ST_IDLE;
            endcase
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (bus.flush_i) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_FIX;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_FIX: begin
          r_busy <= 1'b0;
          if (bus.flush_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at DATA_WIDTH=32.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  mult_div_unit_if #(.DATA_WIDTH(32)) bus ();

  mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse; returns at the negedge after the accepting edge.
  task automatic pulse_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (bus.done_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_no_timeout"}, 64'(n < 100), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    pulse_start(op, a, b);
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
    wait_done(tag, n);
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(exp_lo));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(bus.done_o), 64'd0);
  endtask

  task automatic expect_no_done(input string tag);
    int seen;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) seen = 1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int n;
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.a_i     = 32'd0;
    bus.b_i     = 32'd0;
    bus.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_hi", 64'(bus.hi_o), 64'd0);
    check("rst_lo", 64'(bus.lo_o), 64'd0);

    run_op("mult_neg3x7", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_2p32", 3'b000, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    run_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_100_0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run_op("div_m5_0", 3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_minneg", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_big", 3'b011, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 32'h0FFFFFFF);

    pulse_start(3'b100, 32'h1234, 32'd0);
    check("mthi_hi", 64'(bus.hi_o), 64'h1234);
    check("mthi_busy", 64'(bus.busy_o), 64'd0);
    check("mthi_done", 64'(bus.done_o), 64'd0);
    pulse_start(3'b101, 32'h5678, 32'd0);
    check("mtlo_lo", 64'(bus.lo_o), 64'h5678);
    check("mtlo_hi_kept", 64'(bus.hi_o), 64'h1234);
    check("mtlo_busy", 64'(bus.busy_o), 64'd0);

    pulse_start(3'b110, 32'hAAAA, 32'd1);
    pulse_start(3'b111, 32'hBBBB, 32'd1);
    check("op6_7_hi", 64'(bus.hi_o), 64'h1234);
    check("op6_7_lo", 64'(bus.lo_o), 64'h5678);
    check("op6_7_busy", 64'(bus.busy_o), 64'd0);

    // Starts mid-CALC and in DONE must be dropped.
    pulse_start(3'b001, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    pulse_start(3'b100, 32'hDEAD, 32'd0);
    wait_done("ignore", n);
    check("ignore_latency", 64'(n + 6), 64'd33);
    check("ignore_hi", 64'(bus.hi_o), 64'd0);
    check("ignore_lo", 64'(bus.lo_o), 64'd15);
    bus.start_i = 1'b1;
    bus.op_i    = 3'b101;
    bus.a_i     = 32'hBEEF;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("done_start_lo", 64'(bus.lo_o), 64'd15);
    check("done_start_busy", 64'(bus.busy_o), 64'd0);
    check("done_start_done", 64'(bus.done_o), 64'd0);

    pulse_start(3'b000, 32'd2, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    expect_no_done("flush_no_done");
    check("flush_hi", 64'(bus.hi_o), 64'd0);
    check("flush_lo", 64'(bus.lo_o), 64'd15);

    bus.flush_i = 1'b1;
    pulse_start(3'b001, 32'd2, 32'd3);
    bus.flush_i = 1'b0;
    wait_done("idle_flush", n);
    check("idle_flush_lo", 64'(bus.lo_o), 64'd6);

    pulse_start(3'b001, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 64'(bus.busy_o), 64'd0);
    check("rst_mid_hi", 64'(bus.hi_o), 64'd0);
    check("rst_mid_lo", 64'(bus.lo_o), 64'd0);
    expect_no_done("rst_mid_no_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/HI/LO width; legal values are even and 8..64.
REQ-002 SHALL have parameter CNT_WIDTH, default 6, iteration counter width; 2^CNT_WIDTH > DATA_WIDTH.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, request strobe sampled at the rising edge.
REQ-006 SHALL have port op_i, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-007 SHALL have port a_i, input, DATA_WIDTH: multiplicand/dividend, or MTHI/MTLO write data.
REQ-008 SHALL have port b_i, input, DATA_WIDTH: multiplier/divisor.
REQ-009 SHALL have port flush_i, input, 1, pipeline flush that aborts the current operation.
REQ-010 SHALL have port busy_o, output, 1, high while an operation is in flight; drives the pipeline stall.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port hi_o, output, DATA_WIDTH, HI register.
REQ-013 SHALL have port lo_o, output, DATA_WIDTH, LO register.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; busy_o = (state is CALC or FIX).
REQ-015 In IDLE with start_i=1 and op 000..011, SHALL latch operand magnitudes (signed ops) or raw values (unsigned ops), latch sign flags, clear the counter, and go to CALC.
REQ-016 In IDLE with start_i=1 and op 100/101, SHALL write a_i to HI/LO at that edge, stay in IDLE, and keep done_o low.
REQ-017 In IDLE with start_i=1 and op 110/111, SHALL change nothing.
REQ-018 CALC SHALL run exactly DATA_WIDTH cycles, one radix-2 step per cycle: shift-add multiply or restoring divide, into a 2*DATA_WIDTH working register; then go to FIX.
REQ-019 FIX SHALL apply sign correction for 1 cycle, load HI/LO, and go to DONE.
REQ-020 DONE SHALL assert done_o for exactly 1 cycle, then go to IDLE; start_i is accepted again from IDLE only.
REQ-021 Latency: start accepted at edge t makes done_o high and HI/LO valid in the cycle after edge t+DATA_WIDTH+1.
REQ-022 Multiply: {HI,LO} = full 2*DATA_WIDTH-bit product, two's complement for MULT, unsigned for MULTU.
REQ-023 Divide: LO = quotient, HI = remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-024 Divide by zero (DIV or DIVU): LO = all ones, HI = a_i unmodified; the operation takes normal latency with no error flag.
REQ-025 DIV of most-negative by -1: LO = most-negative value, HI = 0.
REQ-026 start_i while busy_o=1 or in DONE SHALL be ignored and not queued.
REQ-027 flush_i=1 in CALC or FIX SHALL return the FSM to IDLE at that edge, leave HI/LO unchanged, and produce no done_o; flush_i has priority over start_i in the same cycle.
REQ-028 flush_i in IDLE or DONE SHALL have no effect; done_o still pulses in DONE.
REQ-029 hi_o/lo_o SHALL change only at FIX->DONE, at MTHI/MTLO, or at reset.

Reset
REQ-030 On reset=1 at the rising edge: state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter 0; reset has priority over flush_i and start_i.
REQ-031 Reset asserted mid-CALC SHALL abort with no done_o and zero HI/LO.

Verification (DATA_WIDTH=32)
REQ-032 MULT a=0xFFFFFFFD (-3), b=7 -> done_o pulse 33 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100.
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 MTHI 0x1234 then MTLO 0x5678 -> hi_o/lo_o update the next cycle, busy_o stays 0; second start mid-CALC ignored.
REQ-037 flush_i at CALC cycle 10 -> IDLE, no done_o, HI/LO hold prior values; reset mid-CALC -> HI=LO=0.
